// File: rtl/instruction_hold_queue_if.sv
// Handshake bundle between instruction memory, the hold queue and the IF/ID stage.
// master: IM/ID side that drives words, stall and flush; slave: the queue.
interface instruction_hold_queue_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DEPTH     = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_instr;
  logic [ADDR_SIZE-1:0] in_pc;
  logic                 in_ready;
  logic                 instruction_stall;
  logic                 flush;
  logic [DATA_SIZE-1:0] instruction_data;
  logic [ADDR_SIZE-1:0] instruction_pc;
  logic                 instruction_valid;
  logic [CNT_W-1:0]     count;
  logic                 overflow_err;

  modport master (
    output in_valid, in_instr, in_pc, instruction_stall, flush,
    input  in_ready, instruction_data, instruction_pc, instruction_valid, count, overflow_err
  );

  modport slave (
    input  in_valid, in_instr, in_pc, instruction_stall, flush,
    output in_ready, instruction_data, instruction_pc, instruction_valid, count, overflow_err
  );
endinterface

// File: rtl/instruction_hold_queue.sv
// DEPTH-entry circular instruction/PC hold queue between IM and IF/ID; drives a NOP bubble when empty or flushed.
// Optional zero-latency empty-queue bypass is enabled by defining INSTR_HOLD_BYPASS_EN.
module instruction_hold_queue #(
  parameter int unsigned          DATA_SIZE = 32,
  parameter int unsigned          ADDR_SIZE = 32,
  parameter int unsigned          DEPTH     = 2,
  parameter logic [DATA_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  instruction_hold_queue_if.slave bus
);
  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [DATA_SIZE-1:0] mem_instr [DEPTH];
  logic [ADDR_SIZE-1:0] mem_pc    [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count_q;
  logic                 overflow_q;
  logic                 in_ready;
  logic                 held;
  logic                 consume;
  logic                 push;
  logic                 pop;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready = (count_q != FULL);
  assign held     = (count_q != '0) & ~bus.flush;

`ifdef INSTR_HOLD_BYPASS_EN
  // A word that ID takes straight off the bypass never occupies a slot.
  assign consume = (count_q == '0) & bus.in_valid & ~bus.flush & ~bus.instruction_stall;
`else
  assign consume = 1'b0;
`endif

  assign push = bus.in_valid & in_ready & ~bus.flush & ~consume;
  assign pop  = held & ~bus.instruction_stall;

  always_comb begin
    bus.instruction_valid = 1'b0;
    bus.instruction_data  = NOP_INSTR;
    bus.instruction_pc    = '0;
    if (held) begin
      bus.instruction_valid = 1'b1;
      bus.instruction_data  = mem_instr[rd_ptr];
      bus.instruction_pc    = mem_pc[rd_ptr];
    end
`ifdef INSTR_HOLD_BYPASS_EN
    else if ((count_q == '0) & bus.in_valid & ~bus.flush) begin
      bus.instruction_valid = 1'b1;
      bus.instruction_data  = bus.in_instr;
      bus.instruction_pc    = bus.in_pc;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.in_valid & ~in_ready & ~bus.flush) begin
        overflow_q <= 1'b1;
      end
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= next_ptr(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
        if (push & ~pop) begin
          count_q <= count_q + CNT_W'(1);
        end else if (pop & ~push) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

  // Storage carries no reset; only occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= bus.in_instr;
      mem_pc[wr_ptr]    <= bus.in_pc;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.count        = count_q;
  assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_instruction_hold_queue.sv
// Bench for instruction_hold_queue: DEPTH=2 and DEPTH=3 instances share stimulus and are
// checked against a shift-list reference model of the queue.
module tb_instruction_hold_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        stall;
  logic        flush;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instruction_hold_queue_if #(.DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH(2)) if2 ();
  instruction_hold_queue_if #(.DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH(3)) if3 ();

  assign if2.in_valid          = in_valid;
  assign if2.in_instr          = in_instr;
  assign if2.in_pc             = in_pc;
  assign if2.instruction_stall = stall;
  assign if2.flush             = flush;
  assign if3.in_valid          = in_valid;
  assign if3.in_instr          = in_instr;
  assign if3.in_pc             = in_pc;
  assign if3.instruction_stall = stall;
  assign if3.flush             = flush;

  instruction_hold_queue #(.DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH(2), .NOP_INSTR(NOP)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );
  instruction_hold_queue #(.DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH(3), .NOP_INSTR(NOP)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );

  logic        o_valid [2];
  logic [31:0] o_data  [2];
  logic [31:0] o_pc    [2];
  logic        o_ready [2];
  logic        o_ovf   [2];
  int          o_cnt   [2];

  assign o_valid[0] = if2.instruction_valid;
  assign o_data[0]  = if2.instruction_data;
  assign o_pc[0]    = if2.instruction_pc;
  assign o_ready[0] = if2.in_ready;
  assign o_ovf[0]   = if2.overflow_err;
  assign o_cnt[0]   = int'(if2.count);
  assign o_valid[1] = if3.instruction_valid;
  assign o_data[1]  = if3.instruction_data;
  assign o_pc[1]    = if3.instruction_pc;
  assign o_ready[1] = if3.in_ready;
  assign o_ovf[1]   = if3.overflow_err;
  assign o_cnt[1]   = int'(if3.count);

  // Reference model: entry 0 is always the head; pops shift the list down.
  logic [31:0] m_instr [2][4];
  logic [31:0] m_pc    [2][4];
  int          m_cnt   [2];
  logic        m_ovf   [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic bit bypass_on();
`ifdef INSTR_HOLD_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  task automatic exp_head(input int k, output logic v, output logic [31:0] d, output logic [31:0] p);
    v = 1'b0;
    d = NOP;
    p = '0;
    if (!flush) begin
      if (m_cnt[k] > 0) begin
        v = 1'b1;
        d = m_instr[k][0];
        p = m_pc[k][0];
      end else if (bypass_on() && in_valid) begin
        v = 1'b1;
        d = in_instr;
        p = in_pc;
      end
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
      end else if (flush) begin
        m_cnt[k] = 0;
      end else begin
        bit ready;
        bit consume;
        bit do_pop;
        bit do_push;
        ready   = (m_cnt[k] < depth_of(k));
        consume = bypass_on() && (m_cnt[k] == 0) && in_valid && !stall;
        do_pop  = (m_cnt[k] > 0) && !stall;
        do_push = in_valid && ready && !consume;
        if (in_valid && !ready) m_ovf[k] = 1'b1;
        if (do_pop) begin
          for (int i = 0; i < 3; i++) begin
            m_instr[k][i] = m_instr[k][i+1];
            m_pc[k][i]    = m_pc[k][i+1];
          end
          m_cnt[k]--;
        end
        if (do_push) begin
          m_instr[k][m_cnt[k]] = in_instr;
          m_pc[k][m_cnt[k]]    = in_pc;
          m_cnt[k]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_instr = '0;
    in_pc    = '0;
    stall    = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic clear_queues();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hDEAD_BEEF;
    in_pc    = 32'h40;
    stall    = 1'b0;
    flush    = 1'b0;
    model_reset();
    #2;
    checks++; if (if2.instruction_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if2.instruction_valid); end
    checks++; if (if2.instruction_data !== NOP) begin errors++; $display("FAIL reset_data got %h want %h", if2.instruction_data, NOP); end
    checks++; if (if2.instruction_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if2.instruction_pc); end
    checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", if2.in_ready); end
    checks++; if (if2.count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", if2.count); end
    checks++; if (if2.overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", if2.overflow_err); end
    tick();
    tick();
    checks++; if (if2.count !== 2'd0 || if3.count !== 2'd0) begin errors++; $display("FAIL reset_hold_count got %0d/%0d want 0/0", if2.count, if3.count); end
    checks++; if (if3.instruction_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got %b want 0", if3.instruction_valid); end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (if2.instruction_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %b want 0", if2.instruction_valid); end
    tick();
  endtask

  task automatic test_streaming();
    logic [31:0] wi [2] = '{32'h00A0_0093, 32'h0010_0113};
    logic [31:0] wp [2] = '{32'h0, 32'h4};
    logic [31:0] got_i [$];
    logic [31:0] got_p [$];
    logic        ev;
    logic [31:0] ed;
    logic [31:0] ep;
    clear_queues();
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 2);
      if (c < 2) begin
        in_instr = wi[c];
        in_pc    = wp[c];
      end else begin
        in_instr = '0;
        in_pc    = '0;
      end
      @(negedge clk);
      exp_head(0, ev, ed, ep);
      checks++;
      if (if2.instruction_valid !== ev || if2.instruction_data !== ed || if2.instruction_pc !== ep) begin
        errors++;
        $display("FAIL stream_head c%0d got %b/%h/%h want %b/%h/%h", c, if2.instruction_valid,
                 if2.instruction_data, if2.instruction_pc, ev, ed, ep);
      end
      checks++; if (int'(if2.count) > 1) begin errors++; $display("FAIL stream_count c%0d got %0d want <=1", c, if2.count); end
      if (if2.instruction_valid) begin
        got_i.push_back(if2.instruction_data);
        got_p.push_back(if2.instruction_pc);
      end
      tick();
    end
    checks++;
    if (got_i.size() != 2 || got_i[0] !== wi[0] || got_i[1] !== wi[1] || got_p[0] !== wp[0] || got_p[1] !== wp[1]) begin
      errors++;
      $display("FAIL stream_order got %0d words want 2 in order %h,%h", got_i.size(), wi[0], wi[1]);
    end
  endtask

  task automatic test_stall_fill();
    logic [31:0] wi [3] = '{32'h1111_0013, 32'h2222_0013, 32'h3333_0013};
    logic [31:0] wp [3] = '{32'h100, 32'h104, 32'h108};
    clear_queues();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_instr = wi[c];
      in_pc    = wp[c];
      @(negedge clk);
      if (c == 2) begin
        checks++; if (if2.in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full got %b want 0", if2.in_ready); end
      end
      tick();
    end
    checks++; if (if2.count !== 2'd2) begin errors++; $display("FAIL fill_count got %0d want 2", if2.count); end
    checks++; if (if2.overflow_err !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b want 1", if2.overflow_err); end
    checks++; if (if3.overflow_err !== 1'b0) begin errors++; $display("FAIL fill_ovf_d3 got %b want 0", if3.overflow_err); end
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (if2.instruction_valid !== 1'b1 || if2.instruction_data !== wi[c] || if2.instruction_pc !== wp[c]) begin
        errors++;
        $display("FAIL fill_drain%0d got %b/%h/%h want 1/%h/%h", c, if2.instruction_valid,
                 if2.instruction_data, if2.instruction_pc, wi[c], wp[c]);
      end
      tick();
    end
    @(negedge clk);
    checks++; if (if2.instruction_valid !== 1'b0 || if2.count !== 2'd0) begin errors++; $display("FAIL fill_empty got %b/%0d want 0/0", if2.instruction_valid, if2.count); end
    tick();
  endtask

  task automatic test_flush();
    clear_queues();
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_instr = 32'hA000_0013 + 32'(c);
      in_pc    = 32'h200 + 32'(4 * c);
      tick();
    end
    checks++; if (if2.count !== 2'd2) begin errors++; $display("FAIL flush_pre_count got %0d want 2", if2.count); end
    flush    = 1'b1;
    stall    = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hBBBB_0013;
    in_pc    = 32'h300;
    #1;
    checks++;
    if (if2.instruction_valid !== 1'b0 || if2.instruction_data !== NOP || if2.instruction_pc !== 32'h0) begin
      errors++;
      $display("FAIL flush_head got %b/%h/%h want 0/%h/0", if2.instruction_valid, if2.instruction_data, if2.instruction_pc, NOP);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (if2.count !== 2'd0 || if3.count !== 2'd0) begin errors++; $display("FAIL flush_count got %0d/%0d want 0/0", if2.count, if3.count); end
    checks++;
    if (if2.instruction_valid !== 1'b0 || if2.instruction_data !== NOP) begin
      errors++;
      $display("FAIL flush_dropped got %b/%h want 0/%h", if2.instruction_valid, if2.instruction_data, NOP);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_i [$];
    logic [31:0] exp_p [$];
    int          sent = 0;
    int          recv = 0;
    clear_queues();
    for (int c = 0; c < 80 && recv < 7; c++) begin
      in_valid = (sent < 7) && (m_cnt[1] < 3) && ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 2) == 0);
      in_instr = 32'h0C00_0013 + 32'(sent << 8);
      in_pc    = 32'h400 + 32'(4 * sent);
      if (in_valid) begin
        exp_i.push_back(in_instr);
        exp_p.push_back(in_pc);
        sent++;
      end
      @(negedge clk);
      checks++; if (int'(if3.count) !== m_cnt[1]) begin errors++; $display("FAIL wrap_count c%0d got %0d want %0d", c, if3.count, m_cnt[1]); end
      if (if3.instruction_valid && !stall) begin
        checks++;
        if (exp_i.size() == 0 || if3.instruction_data !== exp_i[0] || if3.instruction_pc !== exp_p[0]) begin
          errors++;
          $display("FAIL wrap_order n%0d got %h/%h want %h/%h", recv, if3.instruction_data, if3.instruction_pc,
                   (exp_i.size() != 0) ? exp_i[0] : 32'h0, (exp_p.size() != 0) ? exp_p[0] : 32'h0);
        end
        if (exp_i.size() != 0) begin
          void'(exp_i.pop_front());
          void'(exp_p.pop_front());
        end
        recv++;
      end
      tick();
    end
    checks++; if (recv != 7) begin errors++; $display("FAIL wrap_drained got %0d want 7", recv); end
    idle_inputs();
  endtask

`ifdef INSTR_HOLD_BYPASS_EN
  task automatic test_bypass();
    clear_queues();
    in_valid = 1'b1;
    in_instr = 32'h0050_0293;
    in_pc    = 32'h14;
    #1;
    checks++;
    if (if2.instruction_valid !== 1'b1 || if2.instruction_data !== 32'h0050_0293 || if2.instruction_pc !== 32'h14) begin
      errors++;
      $display("FAIL bypass_head got %b/%h/%h want 1/00500293/00000014", if2.instruction_valid, if2.instruction_data, if2.instruction_pc);
    end
    tick();
    idle_inputs();
    checks++; if (if2.count !== 2'd0) begin errors++; $display("FAIL bypass_count got %0d want 0", if2.count); end
  endtask
`endif

  task automatic test_random();
    logic        ev;
    logic [31:0] ed;
    logic [31:0] ep;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_instr = $urandom;
      in_pc    = 32'h1000 + 32'(4 * c);
      stall    = ($urandom_range(0, 9) < 4);
      flush    = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp_head(k, ev, ed, ep);
        checks++;
        if (o_valid[k] !== ev || o_data[k] !== ed || o_pc[k] !== ep) begin
          errors++;
          $display("FAIL rand_head d%0d c%0d got %b/%h/%h want %b/%h/%h", k, c, o_valid[k], o_data[k], o_pc[k], ev, ed, ep);
        end
        checks++;
        if (o_cnt[k] !== m_cnt[k] || o_ready[k] !== (m_cnt[k] < depth_of(k)) || o_ovf[k] !== m_ovf[k]) begin
          errors++;
          $display("FAIL rand_state d%0d c%0d got cnt%0d rdy%b ovf%b want cnt%0d rdy%b ovf%b", k, c, o_cnt[k],
                   o_ready[k], o_ovf[k], m_cnt[k], (m_cnt[k] < depth_of(k)), m_ovf[k]);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_wrap();
`ifdef INSTR_HOLD_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
